// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address sequencer that drives the 14500 program counter load port.
// Define RETURN_STACK_EN to build the call/return stack; without it calls act as jumps and returns as increments.
module pc_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         pc_clk,
    input  logic                         reset,
    input  logic                         run_i,
    input  logic                         resume_i,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic                         jmp_i,
    input  logic                         rtn_i,
    input  logic                         flg0_i,
    input  logic                         flgf_i,
    input  logic [ADDR_W-1:0]            target_i,
    input  logic [ADDR_W-1:0]            pc_addr_i,
    output logic [ADDR_W-1:0]            pc_addr_o,
    output logic                         pc_addr_w_o,
    output logic                         halted_o,
    output logic                         fault_o,
    output logic [1:0]                   fault_code_o,
    output logic [$clog2(STACK_DEPTH):0] stack_level_o,
    output logic [2:0]                   state_dbg_o
);

    // Handshake: instr_ready_o is high exactly while in FETCH; an instruction transfers on a
    // rising edge where instr_valid_i && instr_ready_o, and instr_valid_i in any other state is dropped.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_UPDATE = 3'd2,
        S_HALT   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_addr_q, pc_addr_d;
    logic              pc_addr_w_q, pc_addr_w_d;
    logic              instr_ready_q, instr_ready_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic              flgf_q, flgf_d;
    logic [ADDR_W-1:0] pc_inc;

`ifdef RETURN_STACK_EN
    localparam int                LVL_W    = $clog2(STACK_DEPTH) + 1;
    localparam int                PTR_W    = $clog2(STACK_DEPTH);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(STACK_DEPTH);

    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
`else
    logic unused_flg0;
    assign unused_flg0 = flg0_i;
`endif

    always_comb begin
        pc_inc       = pc_addr_i + ADDR_W'(1);
        state_d      = state_q;
        pc_addr_d    = pc_addr_q;
        fault_code_d = fault_code_q;
        flgf_d       = flgf_q;
`ifdef RETURN_STACK_EN
        level_d      = level_q;
        stack_d      = stack_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (instr_valid_i) begin
                    flgf_d  = flgf_i;
                    state_d = S_UPDATE;
                    if (jmp_i && rtn_i) begin
                        state_d      = S_FAULT;
                        fault_code_d = 2'd3;
                    end
`ifdef RETURN_STACK_EN
                    else if (jmp_i && flg0_i) begin
                        if (level_q == FULL_LVL) begin
                            state_d      = S_FAULT;
                            fault_code_d = 2'd1;
                        end else begin
                            stack_d[level_q[PTR_W-1:0]] = pc_inc;
                            level_d   = level_q + LVL_W'(1);
                            pc_addr_d = target_i;
                        end
                    end
`endif
                    else if (jmp_i) begin
                        pc_addr_d = target_i;
                    end
`ifdef RETURN_STACK_EN
                    else if (rtn_i) begin
                        if (level_q == '0) begin
                            state_d      = S_FAULT;
                            fault_code_d = 2'd2;
                        end else begin
                            // Top of stack sits one below the occupancy count.
                            level_d   = level_q - LVL_W'(1);
                            pc_addr_d = stack_q[level_d[PTR_W-1:0]];
                        end
                    end
`endif
                    else begin
                        pc_addr_d = pc_inc;
                    end
                end else if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                state_d = flgf_q ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (resume_i) state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state so they line up with it.
        instr_ready_d = (state_d == S_FETCH);
        pc_addr_w_d   = (state_d == S_UPDATE);
        halted_d      = (state_d == S_HALT);
        fault_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge pc_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_addr_q     <= '0;
            pc_addr_w_q   <= 1'b0;
            instr_ready_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'd0;
            flgf_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_addr_q     <= pc_addr_d;
            pc_addr_w_q   <= pc_addr_w_d;
            instr_ready_q <= instr_ready_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            flgf_q        <= flgf_d;
        end
    end

`ifdef RETURN_STACK_EN
    always_ff @(posedge pc_clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            level_q <= level_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign stack_level_o = level_q;
`else
    assign stack_level_o = '0;
`endif

    assign instr_ready_o = instr_ready_q;
    assign pc_addr_o     = pc_addr_q;
    assign pc_addr_w_o   = pc_addr_w_q;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = fault_code_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instructions
// checked against a queue-based reference model of the next-address rules.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef RETURN_STACK_EN
    localparam bit STACK_ON = 1'b1;
`else
    localparam bit STACK_ON = 1'b0;
`endif

    logic              pc_clk;
    logic              reset;
    logic              run_i, resume_i, instr_valid_i;
    logic              jmp_i, rtn_i, flg0_i, flgf_i;
    logic [ADDR_W-1:0] target_i, pc_addr_i;
    logic              instr_ready_o, pc_addr_w_o, halted_o, fault_o;
    logic [ADDR_W-1:0] pc_addr_o;
    logic [1:0]        fault_code_o;
    logic [LVL_W-1:0]  stack_level_o;
    logic [2:0]        dbg_unused_state;

    pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .pc_clk        (pc_clk),
        .reset         (reset),
        .run_i         (run_i),
        .resume_i      (resume_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .jmp_i         (jmp_i),
        .rtn_i         (rtn_i),
        .flg0_i        (flg0_i),
        .flgf_i        (flgf_i),
        .target_i      (target_i),
        .pc_addr_i     (pc_addr_i),
        .pc_addr_o     (pc_addr_o),
        .pc_addr_w_o   (pc_addr_w_o),
        .halted_o      (halted_o),
        .fault_o       (fault_o),
        .fault_code_o  (fault_code_o),
        .stack_level_o (stack_level_o),
        .state_dbg_o   (dbg_unused_state)
    );

    // Clock / reset
    initial pc_clk = 1'b0;
    always #5 pc_clk = ~pc_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: return stack as a queue, last written address, sticky fault code
    logic [ADDR_W-1:0] m_stack[$];
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_code;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic model_exec(input logic j, r, f0, input logic [ADDR_W-1:0] tgt, pc,
                              output logic strobe);
        logic [ADDR_W-1:0] inc;
        inc    = pc + 16'd1;
        strobe = 1'b1;
        if (j && r) begin
            strobe = 1'b0;
            m_code = 2'd3;
        end else if (j && f0 && STACK_ON) begin
            if (m_stack.size() == DEPTH) begin
                strobe = 1'b0;
                m_code = 2'd1;
            end else begin
                m_stack.push_back(inc);
                m_addr = tgt;
            end
        end else if (j) begin
            m_addr = tgt;
        end else if (r && STACK_ON) begin
            if (m_stack.size() == 0) begin
                strobe = 1'b0;
                m_code = 2'd2;
            end else begin
                m_addr = m_stack.pop_back();
            end
        end else begin
            m_addr = inc;
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        reset = 1'b1; run_i = 1'b0; resume_i = 1'b0; instr_valid_i = 1'b0;
        jmp_i = 1'b0; rtn_i = 1'b0; flg0_i = 1'b0; flgf_i = 1'b0;
        target_i = '0; pc_addr_i = '0;
        m_stack.delete(); exp_q.delete();
        m_addr = '0; m_code = 2'd0;
        repeat (2) @(posedge pc_clk);
        @(negedge pc_clk);
        reset = 1'b0;
        @(posedge pc_clk); #1;
    endtask

    task automatic start_run();
        run_i = 1'b1;
        @(posedge pc_clk); #1;
    endtask

    // Waits (bounded) for ready, presents one instruction, returns what the DUT shows one cycle later.
    task automatic issue(input logic j, r, f0, ff, input logic [ADDR_W-1:0] tgt, pc,
                         output logic [23:0] obs);
        int  n;
        logic gr;
        n = 0;
        while (instr_ready_o !== 1'b1 && n < 20) begin
            @(posedge pc_clk); #1;
            n++;
        end
        gr = (instr_ready_o === 1'b1);
        instr_valid_i = 1'b1; jmp_i = j; rtn_i = r; flg0_i = f0; flgf_i = ff;
        target_i = tgt; pc_addr_i = pc;
        @(posedge pc_clk); #1;
        instr_valid_i = 1'b0; jmp_i = 1'b0; rtn_i = 1'b0; flg0_i = 1'b0; flgf_i = 1'b0;
        obs = {gr, pc_addr_w_o, pc_addr_o, fault_o, fault_code_o, stack_level_o};
    endtask

    function automatic logic [23:0] model_view(input logic ew);
        return {1'b1, ew, m_addr, (m_code != 2'd0), m_code, LVL_W'(m_stack.size())};
    endfunction

    task automatic test_reset();
        logic [23:0] obs;
        reset = 1'b1; run_i = 1'b0; resume_i = 1'b0; instr_valid_i = 1'b0;
        jmp_i = 1'b0; rtn_i = 1'b0; flg0_i = 1'b0; flgf_i = 1'b0;
        target_i = '0; pc_addr_i = '0;
        @(posedge pc_clk); #1;
        obs = {instr_ready_o, pc_addr_w_o, pc_addr_o, halted_o, fault_o, fault_code_o, stack_level_o};
        checks++;
        if (obs !== 24'h0) begin
            errors++; $display("FAIL reset_values: got %h want %h", obs, 24'h0);
        end
        do_reset();
        repeat (3) @(posedge pc_clk);
        #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin
            errors++; $display("FAIL idle_not_ready: got %b want 0", instr_ready_o);
        end
        start_run();
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++; $display("FAIL run_to_fetch: got %b want 1", instr_ready_o);
        end
    endtask

    task automatic test_plain();
        logic [23:0] obs, exp_v;
        logic ew;
        do_reset(); start_run();
        for (int i = 0; i < 3; i++) begin
            model_exec(1'b0, 1'b0, 1'b0, '0, 16'h0010 + 16'(i), ew);
            issue(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0010 + 16'(i), obs);
            exp_v = model_view(ew);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL plain[%0d]: got %h want %h", i, obs, exp_v);
            end
            checks++;
            if ({instr_ready_o, pc_addr_w_o} !== 2'b01) begin
                errors++; $display("FAIL update_ready[%0d]: got %b want 01", i, {instr_ready_o, pc_addr_w_o});
            end
            @(posedge pc_clk); #1;
            checks++;
            if ({instr_ready_o, pc_addr_w_o} !== 2'b10) begin
                errors++; $display("FAIL strobe_one_cycle[%0d]: got %b want 10", i, {instr_ready_o, pc_addr_w_o});
            end
        end
        model_exec(1'b0, 1'b0, 1'b0, '0, 16'hFFFF, ew);
        issue(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'hFFFF, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_call_return();
        logic [23:0] obs, exp_v;
        logic ew;
        do_reset(); start_run();
        model_exec(1'b1, 1'b0, 1'b1, 16'h0400, 16'h0100, ew);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0100, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL call: got %h want %h", obs, exp_v);
        end
        model_exec(1'b0, 1'b1, 1'b0, '0, m_addr, ew);
        issue(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0400, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL return: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] obs, exp_v;
        logic [ADDR_W-1:0] pc;
        logic ew;
        do_reset(); start_run();
        pc = 16'h1000;
        for (int i = 0; i < 5; i++) begin
            model_exec(1'b1, 1'b0, 1'b1, 16'h2000 + 16'(i * 256), pc, ew);
            issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h2000 + 16'(i * 256), pc, obs);
            exp_v = model_view(ew);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL nested_call[%0d]: got %h want %h", i, obs, exp_v);
            end
            pc = m_addr;
        end
        repeat (3) @(posedge pc_clk);
        #1;
        exp_v = {(m_code == 2'd0), 1'b0, m_addr, (m_code != 2'd0), m_code, LVL_W'(m_stack.size())};
        obs   = {instr_ready_o, pc_addr_w_o, pc_addr_o, fault_o, fault_code_o, stack_level_o};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL overflow_hold: got %h want %h", obs, exp_v);
        end
        do_reset(); start_run();
        model_exec(1'b0, 1'b1, 1'b0, '0, 16'h0030, ew);
        issue(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0030, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL underflow: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_illegal();
        logic [23:0] obs, exp_v;
        logic ew;
        do_reset(); start_run();
        model_exec(1'b0, 1'b0, 1'b0, '0, 16'h0050, ew);
        issue(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0050, obs);
        model_exec(1'b1, 1'b1, 1'b0, 16'h0777, 16'h0051, ew);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0777, 16'h0051, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL illegal: got %h want %h", obs, exp_v);
        end
        instr_valid_i = 1'b1; jmp_i = 1'b1; target_i = 16'h0999; resume_i = 1'b1;
        repeat (4) @(posedge pc_clk);
        #1;
        instr_valid_i = 1'b0; jmp_i = 1'b0; resume_i = 1'b0;
        obs   = {instr_ready_o, pc_addr_w_o, pc_addr_o, fault_o, fault_code_o, stack_level_o};
        exp_v = {1'b0, 1'b0, 16'h0051, 1'b1, 2'd3, LVL_W'(0)};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL fault_sticky: got %h want %h", obs, exp_v);
        end
        do_reset();
        checks++;
        if ({fault_o, fault_code_o} !== 3'b000) begin
            errors++; $display("FAIL fault_cleared: got %b want 000", {fault_o, fault_code_o});
        end
    endtask

    task automatic test_halt();
        logic [23:0] obs, exp_v;
        logic ew;
        do_reset(); start_run();
        model_exec(1'b0, 1'b0, 1'b0, '0, 16'h0020, ew);
        issue(1'b0, 1'b0, 1'b0, 1'b1, '0, 16'h0020, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL halt_instr: got %h want %h", obs, exp_v);
        end
        instr_valid_i = 1'b1;
        repeat (4) @(posedge pc_clk);
        #1;
        instr_valid_i = 1'b0;
        checks++;
        if ({halted_o, instr_ready_o, pc_addr_w_o} !== 3'b100) begin
            errors++; $display("FAIL halted: got %b want 100", {halted_o, instr_ready_o, pc_addr_w_o});
        end
        resume_i = 1'b1;
        @(posedge pc_clk); #1;
        resume_i = 1'b0;
        checks++;
        if ({halted_o, instr_ready_o} !== 2'b01) begin
            errors++; $display("FAIL resume: got %b want 01", {halted_o, instr_ready_o});
        end
        run_i = 1'b0;
        @(posedge pc_clk); #1;
        resume_i = 1'b1;
        @(posedge pc_clk); #1;
        resume_i = 1'b0;
        checks++;
        if ({halted_o, instr_ready_o} !== 2'b00) begin
            errors++; $display("FAIL fetch_to_idle: got %b want 00", {halted_o, instr_ready_o});
        end
        start_run();
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++; $display("FAIL rerun: got %b want 1", instr_ready_o);
        end
    endtask

    task automatic test_reset_mid_update();
        logic [23:0] obs, exp_v;
        logic ew;
        do_reset(); start_run();
        model_exec(1'b1, 1'b0, 1'b1, 16'h0600, 16'h0300, ew);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0600, 16'h0300, obs);
        exp_v = model_view(ew);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL pre_abort: got %h want %h", obs, exp_v);
        end
        reset = 1'b1;
        #1;
        obs = {instr_ready_o, pc_addr_w_o, pc_addr_o, fault_o, fault_code_o, stack_level_o};
        checks++;
        if (obs !== 24'h0) begin
            errors++; $display("FAIL abort_update: got %h want %h", obs, 24'h0);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [23:0] obs, exp_v;
        logic [ADDR_W-1:0] pc, tgt, want;
        logic j, r, f0, ff, ew;
        do_reset(); start_run();
        for (int i = 0; i < 80; i++) begin
            j   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 2) == 0);
            f0  = ($urandom_range(0, 1) == 0);
            ff  = ($urandom_range(0, 7) == 0);
            pc  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : ADDR_W'($urandom);
            tgt = ADDR_W'($urandom);
            model_exec(j, r, f0, tgt, pc, ew);
            if (ew) exp_q.push_back(m_addr);
            issue(j, r, f0, ff, tgt, pc, obs);
            exp_v = model_view(ew);
            checks++;
            if ({obs[23:22], obs[5:0]} !== {exp_v[23:22], exp_v[5:0]}) begin
                errors++; $display("FAIL rand_status[%0d]: got %h want %h", i, obs, exp_v);
            end
            if (obs[22] === 1'b1) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : ~obs[21:6];
                checks++;
                if (obs[21:6] !== want) begin
                    errors++; $display("FAIL rand_addr[%0d]: got %h want %h", i, obs[21:6], want);
                end
            end
            if (m_code != 2'd0) begin
                do_reset(); start_run();
            end else if (ff) begin
                @(posedge pc_clk); #1;
                checks++;
                if (halted_o !== 1'b1) begin
                    errors++; $display("FAIL rand_halt[%0d]: got %b want 1", i, halted_o);
                end
                resume_i = 1'b1;
                @(posedge pc_clk); #1;
                resume_i = 1'b0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_missing_strobes: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_plain();
        test_call_return();
        test_overflow();
        test_illegal();
        test_halt();
        test_reset_mid_update();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
